// File: rtl/fetch_stage_8085.sv
// Instruction-fetch stage: owns the PC, predicts taken jumps through a small
// fully-associative lookup table and presents a registered IF/ID output.
// Execute-side jump resolution redirects the PC and flushes on a mispredict.
module fetch_stage_8085 #(
    parameter int unsigned AW        = 16,
    parameter int unsigned IW        = 8,
    parameter int unsigned LUT_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    input  logic          hold,
    input  logic          ex_jump,
    input  logic          ex_taken,
    input  logic          ex_pred,
    input  logic [AW-1:0] ex_pc,
    input  logic [AW-1:0] ex_target,
    output logic [AW-1:0] pc,
    output logic [IW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    output logic          if_pred,
    output logic          if_valid,
    output logic          stall_jump
);

    localparam int unsigned PW = $clog2(LUT_DEPTH);

    // Fetch pipeline state
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] if_instr_q, if_instr_d;
    logic [AW-1:0] if_pc_q, if_pc_d;
    logic          if_pred_q, if_pred_d;
    logic          if_valid_q, if_valid_d;
    logic          stall_jump_q, stall_jump_d;

    // Jump lookup table state
    logic [LUT_DEPTH-1:0] lut_valid_q, lut_valid_d;
    logic [AW-1:0]        lut_tag_q    [LUT_DEPTH];
    logic [AW-1:0]        lut_tag_d    [LUT_DEPTH];
    logic [AW-1:0]        lut_target_q [LUT_DEPTH];
    logic [AW-1:0]        lut_target_d [LUT_DEPTH];
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

    logic          lut_hit;
    logic [AW-1:0] lut_hit_target;
    logic          upd_hit;
    logic [PW-1:0] upd_idx;
    logic          mispredict;

    assign mispredict = ex_jump & (ex_taken ^ ex_pred);

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign if_pred    = if_pred_q;
    assign if_valid   = if_valid_q;
    assign stall_jump = stall_jump_q;

    // Prediction lookup on the current PC (sees pre-update table contents)
    always_comb begin
        lut_hit        = 1'b0;
        lut_hit_target = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (lut_valid_q[i] && (lut_tag_q[i] == pc_q)) begin
                lut_hit        = 1'b1;
                lut_hit_target = lut_target_q[i];
            end
        end
    end

    // Match the resolved jump address against the table for update
    always_comb begin
        upd_hit = 1'b0;
        upd_idx = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (lut_valid_q[i] && (lut_tag_q[i] == ex_pc)) begin
                upd_hit = 1'b1;
                upd_idx = PW'(i);
            end
        end
    end

    // Table next-state: retarget/allocate on taken, invalidate on not-taken hit
    always_comb begin
        lut_valid_d  = lut_valid_q;
        lut_tag_d    = lut_tag_q;
        lut_target_d = lut_target_q;
        rr_ptr_d     = rr_ptr_q;
        if (ex_jump) begin
            if (ex_taken) begin
                if (upd_hit) begin
                    lut_target_d[upd_idx] = ex_target;
                end else begin
                    lut_valid_d[rr_ptr_q]  = 1'b1;
                    lut_tag_d[rr_ptr_q]    = ex_pc;
                    lut_target_d[rr_ptr_q] = ex_target;
                    rr_ptr_d               = rr_ptr_q + PW'(1);
                end
            end else if (upd_hit) begin
                lut_valid_d[upd_idx] = 1'b0;
            end
        end
    end

    // Fetch next-state: mispredict beats hold; hold freezes PC and IF/ID
    always_comb begin
        pc_d         = pc_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        if_pred_d    = if_pred_q;
        if_valid_d   = if_valid_q;
        stall_jump_d = 1'b0;
        if (mispredict) begin
            pc_d         = ex_taken ? ex_target : (ex_pc + AW'(1));
            if_valid_d   = 1'b0;
            if_pred_d    = 1'b0;
            stall_jump_d = 1'b1;
        end else if (!hold) begin
            if_instr_d = imem_data;
            if_pc_d    = pc_q;
            if_pred_d  = lut_hit;
            if_valid_d = 1'b1;
            pc_d       = lut_hit ? lut_hit_target : (pc_q + AW'(1));
        end
    end

    // Fetch pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= '0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
            if_pred_q    <= 1'b0;
            if_valid_q   <= 1'b0;
            stall_jump_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_pred_q    <= if_pred_d;
            if_valid_q   <= if_valid_d;
            stall_jump_q <= stall_jump_d;
        end
    end

    // Lookup table registers; reset discards all entries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lut_valid_q <= '0;
            rr_ptr_q    <= '0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_tag_q[i]    <= '0;
                lut_target_q[i] <= '0;
            end
        end else begin
            lut_valid_q  <= lut_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            lut_tag_q    <= lut_tag_d;
            lut_target_q <= lut_target_d;
        end
    end

endmodule
